// File: rtl/serial_frame_tx.sv
// -----------------------------------------------------------------------------
// serial_frame_tx
//
// Parallel-in, serial-out frame transmitter. A word accepted on a valid/ready
// handshake is sent on tx_o as: start bit (0), data LSB first, optional even
// parity bit, stop bit (1). Every bit is held for CLKS_PER_BIT clock cycles.
//
// Build option:
//   SERIAL_TX_PARITY_EN  defined   -> PARITY state present, even-parity bit
//                                     sent between the last data bit and stop
//                        undefined -> DATA goes straight to STOP
//
// Parameters:
//   DATA_W        data word width, 1..16
//   CLKS_PER_BIT  clock cycles per bit, >= 1
//
// Ports:
//   clk_i    single clock, rising edge
//   rst_i    asynchronous, active-high reset
//   data_i   word to send, sampled only at accept
//   valid_i  requester has a word on data_i
//   ready_o  idle and able to accept (registered)
//   tx_o     serial line, idles high (registered)
//   busy_o   frame in progress, always the inverse of ready_o (registered)
//   done_o   one-cycle pulse on the first cycle back in IDLE (registered)
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | line high, ready for a word; done_o high on the first cycle here
// START | start bit (0) on the line
// DATA  | shift_q[0] on the line, shifted right at each bit boundary
// PARITY| even parity of the latched word (only with SERIAL_TX_PARITY_EN)
// STOP  | stop bit (1) on the line
// -----------------------------------------------------------------------------
module serial_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SERIAL_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t            state_q;
  logic [TICK_W-1:0] tick_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_nxt;
  logic              bit_end;

`ifdef SERIAL_TX_PARITY_EN
  // Parity is taken from data_i at accept, since shift_q is consumed as the
  // frame goes out.
  logic              parity_q;
`endif

  assign shift_nxt = shift_q >> 1;
  assign bit_end   = (tick_q == TICK_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_o      <= 1'b1;
      ready_o   <= 1'b1;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // ready_o is high throughout IDLE, so valid_i alone means accept.
          if (valid_i) begin
            shift_q   <= data_i;
            tick_q    <= '0;
            bit_cnt_q <= '0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q  <= ^data_i;
`endif
            tx_o      <= 1'b0;
            ready_o   <= 1'b0;
            busy_o    <= 1'b1;
            state_q   <= S_START;
          end
        end

        S_START: begin
          if (bit_end) begin
            tick_q  <= '0;
            tx_o    <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            tick_q  <= '0;
            shift_q <= shift_nxt;
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_q <= '0;
`ifdef SERIAL_TX_PARITY_EN
              tx_o      <= parity_q;
              state_q   <= S_PARITY;
`else
              tx_o      <= 1'b1;
              state_q   <= S_STOP;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              tx_o      <= shift_nxt[0];
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end

`ifdef SERIAL_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            tick_q  <= '0;
            tx_o    <= 1'b1;
            state_q <= S_STOP;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (bit_end) begin
            tick_q  <= '0;
            ready_o <= 1'b1;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end

        default: begin
          tx_o    <= 1'b1;
          ready_o <= 1'b1;
          busy_o  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
module tb_serial_frame_tx;

`ifdef SERIAL_TX_PARITY_EN
  localparam int LEN_A = 44;   // (8+3)*4
  localparam int LEN_B = 4;    // (1+3)*1
`else
  localparam int LEN_A = 40;   // (8+2)*4
  localparam int LEN_B = 3;    // (1+2)*1
`endif
  localparam int CPB_A = 4;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  // Instance A: DATA_W=8, CLKS_PER_BIT=4
  logic [7:0] data_a;
  logic       valid_a;
  logic       ready_a, tx_a, busy_a, done_a;

  // Instance B: DATA_W=1, CLKS_PER_BIT=1
  logic [0:0] data_b;
  logic       valid_b;
  logic       ready_b, tx_b, busy_b, done_b;

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) u_dut_a (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .data_i  (data_a),
    .valid_i (valid_a),
    .ready_o (ready_a),
    .tx_o    (tx_a),
    .busy_o  (busy_a),
    .done_o  (done_a)
  );

  serial_frame_tx #(.DATA_W(1), .CLKS_PER_BIT(1)) u_dut_b (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .data_i  (data_b),
    .valid_i (valid_b),
    .ready_o (ready_b),
    .tx_o    (tx_b),
    .busy_o  (busy_b),
    .done_o  (done_b)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Scoreboard: expected line level per busy cycle, expected frame lengths.
  bit exp_a[$];
  int len_a[$];
  bit exp_b[$];
  int len_b[$];
  int cyc_a = 0, gap_a = 0, last_gap_a = 0;
  int cyc_b = 0;

  task automatic check(input string nm, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic fail(input string nm, input int act, input int exp);
    chk_cnt++;
    $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic void push_a(input logic [7:0] d);
    for (int c = 0; c < CPB_A; c++) exp_a.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < CPB_A; c++) exp_a.push_back(d[i]);
`ifdef SERIAL_TX_PARITY_EN
    for (int c = 0; c < CPB_A; c++) exp_a.push_back(^d);
`endif
    for (int c = 0; c < CPB_A; c++) exp_a.push_back(1'b1);
    len_a.push_back(LEN_A);
  endfunction

  function automatic void push_b(input logic d);
    exp_b.push_back(1'b0);
    exp_b.push_back(d);
`ifdef SERIAL_TX_PARITY_EN
    exp_b.push_back(d);
`endif
    exp_b.push_back(1'b1);
    len_b.push_back(LEN_B);
  endfunction

  // Monitor A
  always @(negedge clk_i) begin
    if (rst_i) begin
      exp_a.delete();
      len_a.delete();
      cyc_a = 0;
    end else begin
      check("ready_vs_busy_a", int'(ready_a), int'(!busy_a));
      if (busy_a) begin
        if (cyc_a == 0) begin
          last_gap_a = gap_a;
          gap_a      = 0;
        end
        if (exp_a.size() == 0) fail("tx_a_unexpected_busy", 1, 0);
        else check("tx_a_bit", int'(tx_a), int'(exp_a.pop_front()));
        cyc_a++;
      end else begin
        gap_a++;
        check("tx_a_idle_high", int'(tx_a), 1);
      end
      if (done_a) begin
        if (len_a.size() == 0) fail("done_a_unexpected", 1, 0);
        else check("frame_len_a", cyc_a, len_a.pop_front());
        cyc_a = 0;
      end
    end
  end

  // Monitor B
  always @(negedge clk_i) begin
    if (rst_i) begin
      exp_b.delete();
      len_b.delete();
      cyc_b = 0;
    end else begin
      if (busy_b) begin
        if (exp_b.size() == 0) fail("tx_b_unexpected_busy", 1, 0);
        else check("tx_b_bit", int'(tx_b), int'(exp_b.pop_front()));
        cyc_b++;
      end else if (!tx_b) begin
        fail("tx_b_idle_high", int'(tx_b), 1);
      end
      if (done_b) begin
        if (len_b.size() == 0) fail("done_b_unexpected", 1, 0);
        else check("frame_len_b", cyc_b, len_b.pop_front());
        cyc_b = 0;
      end
    end
  end

  task automatic send_a(input logic [7:0] d);
    int n = 0;
    @(negedge clk_i);
    data_a  = d;
    valid_a = 1'b1;
    while (!ready_a && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    if (!ready_a) fail("send_a_timeout", 0, 1);
    else push_a(d);
    @(negedge clk_i);
    valid_a = 1'b0;
    data_a  = ~d;  // later data_i changes must not reach the line
  endtask

  task automatic send_b(input logic d);
    int n = 0;
    @(negedge clk_i);
    data_b  = d;
    valid_b = 1'b1;
    while (!ready_b && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (!ready_b) fail("send_b_timeout", 0, 1);
    else push_b(d);
    @(negedge clk_i);
    valid_b = 1'b0;
    data_b  = ~d;
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while ((len_a.size() != 0 || !ready_a) && n < 1000) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 1000) fail("wait_idle_a_timeout", 0, 1);
    @(negedge clk_i);
  endtask

  task automatic wait_idle_b();
    int n = 0;
    while ((len_b.size() != 0 || !ready_b) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 200) fail("wait_idle_b_timeout", 0, 1);
    @(negedge clk_i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i   = 1'b1;
    data_a  = '0;
    valid_a = 1'b0;
    data_b  = '0;
    valid_b = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("rst_tx_a", int'(tx_a), 1);
    check("rst_ready_a", int'(ready_a), 1);
    check("rst_busy_a", int'(busy_a), 0);
    check("rst_done_a", int'(done_a), 0);
    check("rst_tx_b", int'(tx_b), 1);

    // Single frame
    send_a(8'hA5);
    wait_idle_a();

    // Back-to-back: second accept lands in the done_o cycle
    send_a(8'h00);
    send_a(8'hFF);
    wait_idle_a();
    check("b2b_idle_gap", last_gap_a, 1);

    // valid_i pulsed mid-frame must be ignored
    send_a(8'h96);
    repeat (10) @(negedge clk_i);
    data_a  = 8'h3C;
    valid_a = 1'b1;
    @(negedge clk_i);
    valid_a = 1'b0;
    wait_idle_a();
    repeat (60) @(negedge clk_i);
    check("no_extra_frame_ready", int'(ready_a), 1);

    // Reset in the middle of data bit 0 (0x5A bit0 = 0)
    send_a(8'h5A);
    repeat (7) @(negedge clk_i);
    check("pre_rst_tx_low", int'(tx_a), 0);
    #2 rst_i = 1'b1;
    #1;
    check("midrst_tx_a", int'(tx_a), 1);
    check("midrst_ready_a", int'(ready_a), 1);
    check("midrst_busy_a", int'(busy_a), 0);
    check("midrst_done_a", int'(done_a), 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (60) @(negedge clk_i);
    check("post_rst_ready_a", int'(ready_a), 1);

    // Recovery after reset
    send_a(8'hC3);
    wait_idle_a();

    // DATA_W=1, CLKS_PER_BIT=1
    send_b(1'b1);
    wait_idle_b();
    send_b(1'b0);
    send_b(1'b1);
    wait_idle_b();

    check("exp_a_drained", exp_a.size(), 0);
    check("exp_b_drained", exp_b.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
